bcd_sum_ssd_scan: RTL and testbench

Downstream consumer of the single-digit BCD adder. Captures operands A, B and the adder result {co, s} on a load strobe and holds them. Drives a 4-digit multiplexed common-anode seven-segment display: digit3=A, digit2=B, digit1=carry, digit0=sum. Sits between the adder and the board display pins.

---
 rtl/bcd_sum_ssd_scan_pkg.sv | 21 ++
 rtl/bcd_to_ssd.sv | 29 ++
 rtl/bcd_sum_ssd_scan.sv | 121 ++++++++++++
 tb/tb_bcd_sum_ssd_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sum_ssd_scan_pkg.sv
// Shared definitions for the BCD sum seven-segment scanner.
// Segment encodings are {dp,g,f,e,d,c,b,a}, active-low, decimal point always off.
package bcd_sum_ssd_scan_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit position on the display: 0 = sum, 1 = carry, 2 = B, 3 = A.
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_ssd.sv
// Combinational BCD digit to seven-segment decoder.
// Ports:
//   bcd - 4-bit digit; values 10..15 are not BCD and show "E"
//   seg - active-low segments {dp,g,f,e,d,c,b,a}
module bcd_to_ssd
  import bcd_sum_ssd_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_sum_ssd_scan.sv
// Captures a BCD addition (A, B, sum, carry) on a load strobe and scans it onto a
// 4-digit multiplexed common-anode seven-segment display.
//   digit3 = A, digit2 = B, digit1 = carry, digit0 = sum
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   load              - capture strobe for a_bcd/b_bcd/sum_bcd/sum_co
//   a_bcd, b_bcd      - operand digits
//   sum_bcd, sum_co   - adder result digit and decimal carry
//   ssd_seg           - registered active-low segments {dp,g,f,e,d,c,b,a}
//   ssd_an            - registered active-low one-hot digit anodes
//   ovf               - captured carry
// Parameters:
//   SCAN_DIV          - clock cycles each digit stays lit (>= 2)
//   BLANK_CO          - 1: carry digit dark when carry is 0; 0: shows "0"
module bcd_sum_ssd_scan
  import bcd_sum_ssd_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_CO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] a_bcd,
  input  logic [3:0] b_bcd,
  input  logic [3:0] sum_bcd,
  input  logic       sum_co,
  output logic [7:0] ssd_seg,
  output logic [3:0] ssd_an,
  output logic       ovf
);

  localparam int unsigned    CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [3:0]      a_q, a_d, b_q, b_d, s_q, s_d;
  logic            co_q, co_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;

  logic [3:0]      sel_digit;
  logic            sel_blank;
  logic [7:0]      dec_seg;

  // Capture registers and scan prescaler; load is independent of the scan.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    co_d  = co_q;
    if (load) begin
      a_d  = a_bcd;
      b_d  = b_bcd;
      s_d  = sum_bcd;
      co_d = sum_co;
    end

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Digit mux ahead of the single shared decoder.
  always_comb begin
    sel_digit = s_q;
    sel_blank = 1'b0;
    unique case (idx_q)
      2'd0: sel_digit = s_q;
      2'd1: begin
        sel_digit = {3'b000, co_q};
        sel_blank = BLANK_CO && !co_q;
      end
      2'd2: sel_digit = b_q;
      2'd3: sel_digit = a_q;
      default: sel_digit = s_q;
    endcase
  end

  bcd_to_ssd u_dec (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  // Output stage registers the current index and data, giving one cycle of latency.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = sel_blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      co_q  <= co_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign ssd_seg = seg_q;
  assign ssd_an  = an_q;
  assign ovf     = co_q;

endmodule

// File: tb/tb_bcd_sum_ssd_scan.sv
module tb_bcd_sum_ssd_scan;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] a_bcd, b_bcd, sum_bcd;
  logic       sum_co;
  logic [7:0] seg1, seg0;
  logic [3:0] an1, an0;
  logic       ovf1, ovf0;

  // dut_b: carry digit blanked when 0; dut_n: carry digit shows "0".
  bcd_sum_ssd_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CO(1'b1)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .sum_bcd (sum_bcd),
    .sum_co  (sum_co),
    .ssd_seg (seg1),
    .ssd_an  (an1),
    .ovf     (ovf1)
  );

  bcd_sum_ssd_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CO(1'b0)) dut_n (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .sum_bcd (sum_bcd),
    .sum_co  (sum_co),
    .ssd_seg (seg0),
    .ssd_an  (an0),
    .ovf     (ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; output after edge k reflects index ((k-1)/SCAN_DIV)%4.
  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       co;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;
    logic [7:0] seg1_nb;
  } vec_t;

  vec_t vecs[7];
  vec_t cur;
  vec_t zero_v;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input string tag);
    int         idx;
    logic [3:0] exp_an;
    logic [7:0] e_b, e_n;
    idx    = ((edges - 1) / SCAN_DIV) % 4;
    exp_an = ~(4'b0001 << idx);
    case (idx)
      0:       begin e_b = cur.seg0; e_n = cur.seg0;    end
      1:       begin e_b = cur.seg1; e_n = cur.seg1_nb; end
      2:       begin e_b = cur.seg2; e_n = cur.seg2;    end
      default: begin e_b = cur.seg3; e_n = cur.seg3;    end
    endcase
    chk({tag, " an_b"},  {4'h0, an1}, {4'h0, exp_an});
    chk({tag, " an_n"},  {4'h0, an0}, {4'h0, exp_an});
    chk({tag, " seg_b"}, seg1, e_b);
    chk({tag, " seg_n"}, seg0, e_n);
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, " an_b"},  {4'h0, an1}, 8'h0F);
    chk({tag, " an_n"},  {4'h0, an0}, 8'h0F);
    chk({tag, " seg_b"}, seg1, 8'hFF);
    chk({tag, " seg_n"}, seg0, 8'hFF);
    chk({tag, " ovf_b"}, {7'h0, ovf1}, 8'h00);
    chk({tag, " ovf_n"}, {7'h0, ovf0}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    n_checks = 0;
    n_fail   = 0;

    //            a     b     s     co    seg0   seg1   seg2   seg3   seg1_nb
    zero_v  = '{4'h0, 4'h0, 4'h0, 1'b0, 8'hC0, 8'hFF, 8'hC0, 8'hC0, 8'hC0};
    vecs[0] = '{4'h7, 4'h5, 4'h2, 1'b1, 8'hA4, 8'hF9, 8'h92, 8'hF8, 8'hF9};
    vecs[1] = '{4'h3, 4'h4, 4'h7, 1'b0, 8'hF8, 8'hFF, 8'h99, 8'hB0, 8'hC0};
    vecs[2] = '{4'hF, 4'h0, 4'hB, 1'b1, 8'h86, 8'hF9, 8'hC0, 8'h86, 8'hF9};
    vecs[3] = '{4'h9, 4'h8, 4'h7, 1'b1, 8'hF8, 8'hF9, 8'h80, 8'h90, 8'hF9};
    vecs[4] = '{4'h0, 4'h6, 4'h6, 1'b0, 8'h82, 8'hFF, 8'h82, 8'hC0, 8'hC0};
    vecs[5] = '{4'h5, 4'h5, 4'h0, 1'b1, 8'hC0, 8'hF9, 8'h92, 8'h92, 8'hF9};
    vecs[6] = '{4'h1, 4'h2, 4'h3, 1'b0, 8'hB0, 8'hFF, 8'hA4, 8'hF9, 8'hC0};

    rst_n   = 1'b0;
    load    = 1'b0;
    a_bcd   = 4'h0;
    b_bcd   = 4'h0;
    sum_bcd = 4'h0;
    sum_co  = 1'b0;

    // Reset state held across clock edges.
    repeat (3) @(negedge clk);
    check_reset_pins("reset");

    // Release: scan starts at digit0 with cleared data.
    rst_n = 1'b1;
    cur   = zero_v;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clk);
      check_cycle("reset_scan");
    end

    // Table-driven captures, each checked over one full scan period.
    for (int v = 0; v < 7; v++) begin
      a_bcd   = vecs[v].a;
      b_bcd   = vecs[v].b;
      sum_bcd = vecs[v].s;
      sum_co  = vecs[v].co;
      load    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("ovf_b", {7'h0, ovf1}, {7'h0, vecs[v].co});
      chk("ovf_n", {7'h0, ovf0}, {7'h0, vecs[v].co});
      cur = vecs[v];
      @(posedge clk);
      for (int i = 0; i < 4 * SCAN_DIV; i++) begin
        @(negedge clk);
        check_cycle("vec");
      end
    end

    // Bus changes without load must not reach the display.
    a_bcd   = 4'h9;
    b_bcd   = 4'h9;
    sum_bcd = 4'h9;
    sum_co  = 1'b1;
    for (int i = 0; i < 8 * SCAN_DIV; i++) begin
      @(negedge clk);
      check_cycle("hold");
    end
    chk("hold ovf_b", {7'h0, ovf1}, 8'h00);

    // Load on the prescaler wrap edge.
    w = 0;
    while ((edges % SCAN_DIV) != SCAN_DIV - 1 && w < 2 * SCAN_DIV) begin
      @(negedge clk);
      w++;
    end
    chk("wrap_align", {7'h0, ((edges % SCAN_DIV) == SCAN_DIV - 1)}, 8'h01);
    a_bcd   = vecs[0].a;
    b_bcd   = vecs[0].b;
    sum_bcd = vecs[0].s;
    sum_co  = vecs[0].co;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    check_cycle("wrap_old");
    cur = vecs[0];
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      @(negedge clk);
      check_cycle("wrap_new");
    end
    chk("wrap ovf_b", {7'h0, ovf1}, 8'h01);

    // Asynchronous reset mid-digit, observed before the next clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_pins("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = zero_v;
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      @(negedge clk);
      check_cycle("post_reset");
    end
    chk("post_reset ovf_b", {7'h0, ovf1}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
